sample_mixer: RTL and testbench

// - Downstream of channels, upstream of i2s: sums channel_a+channel_c (L) and channel_b+channel_d (R).
// - Applies master attenuation and soft mute ramp; saturates to SAMPLE_WIDTH; holds result for serializer.
// - Replaces inline mix/clamp logic in top level; drives ac_mute_n.

---
 rtl/sample_mixer_pkg.sv | 16 +
 rtl/sample_mixer_saturate.sv | 24 ++
 rtl/sample_mixer.sv | 230 +++++++++++++++++++++++
 tb/tb_sample_mixer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/sample_mixer_pkg.sv
// Shared widths and mute state encoding for the sample mixer.
// Imported by sample_mixer and sample_saturate.
package sample_mixer_pkg;

    localparam int SAMPLE_WIDTH = 16;
    localparam int ATTEN_WIDTH  = 4;
    localparam int ATTEN_MAX    = 2**ATTEN_WIDTH - 1;

    typedef enum logic [1:0] {
        UNMUTED,
        RAMP_DOWN,
        MUTED,
        RAMP_UP
    } mute_state_t;

endpackage

// File: rtl/sample_mixer_saturate.sv
// Signed clamp of a W+1 bit value into W bits with a clip indication.
// One instance per output channel.
module sample_saturate
    import sample_mixer_pkg::*;
#(
    parameter int W = SAMPLE_WIDTH
) (
    input  logic signed [W:0]   in_i,
    output logic signed [W-1:0] out_o,
    output logic                clip_o
);

    // Overflow exactly when the two top bits disagree.
    always_comb begin
        out_o  = in_i[W-1:0];
        clip_o = 1'b0;
        if (in_i[W] != in_i[W-1]) begin
            clip_o = 1'b1;
            out_o  = in_i[W] ? {1'b1, {(W-1){1'b0}}}
                             : {1'b0, {(W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/sample_mixer.sv
// Channel mixer: L=a+c, R=b+d, attenuate, soft mute ramp, saturate, hold.
// Optional sticky clip flags under SAMPLE_MIXER_CLIP_DETECT_EN.
module sample_mixer #(
    parameter int SAMPLE_WIDTH = sample_mixer_pkg::SAMPLE_WIDTH,
    parameter int ATTEN_WIDTH  = sample_mixer_pkg::ATTEN_WIDTH,
    parameter int RAMP_DIV     = 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           sample_clk_en,
    input  logic signed [SAMPLE_WIDTH-1:0] channel_a,
    input  logic signed [SAMPLE_WIDTH-1:0] channel_b,
    input  logic signed [SAMPLE_WIDTH-1:0] channel_c,
    input  logic signed [SAMPLE_WIDTH-1:0] channel_d,
    input  logic [ATTEN_WIDTH-1:0]         atten,
    input  logic                           mute_req,
    output logic signed [SAMPLE_WIDTH-1:0] sample_l,
    output logic signed [SAMPLE_WIDTH-1:0] sample_r,
    output logic                           sample_valid,
    input  logic                           sample_ready,
    output logic                           ac_mute_n,
    output logic [7:0]                     overrun_cnt,
    output logic                           clip_l,
    output logic                           clip_r,
    input  logic                           clip_clr
);

    import sample_mixer_pkg::*;

    localparam int SW1 = SAMPLE_WIDTH + 1;
    localparam int DW  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [ATTEN_WIDTH-1:0] ATT_TOP = '1;

    mute_state_t state_q, state_d;
    logic [ATTEN_WIDTH-1:0] cur_q, cur_d;
    logic [ATTEN_WIDTH-1:0] base, base_inc, cur_dec;
    logic [DW-1:0] div_q, div_d;
    logic step;

    logic s1_vld_q, s2_vld_q;
    logic signed [SW1-1:0] sum_l_q, sum_r_q;
    logic signed [SW1-1:0] shl_l_q, shl_r_q;
    logic signed [SAMPLE_WIDTH-1:0] sat_l, sat_r;
    logic clip_l_raw, clip_r_raw;

    logic signed [SAMPLE_WIDTH-1:0] out_l_q, out_r_q;
    logic valid_q, valid_d;
    logic [7:0] ovr_q, ovr_d;
    logic load;

    assign step = sample_clk_en && (div_q == DW'(RAMP_DIV - 1));

    // Ramp divider counts strobes between attenuation steps.
    always_comb begin
        div_d = div_q;
        if (sample_clk_en) begin
            div_d = step ? '0 : div_q + DW'(1);
        end
    end

    // Mute FSM: one attenuation step per divided strobe.
    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        base     = (state_q == UNMUTED) ? atten : cur_q;
        base_inc = base + 1'b1;
        cur_dec  = cur_q - 1'b1;
        if (sample_clk_en && !step) begin
            if (state_q == UNMUTED) begin
                cur_d = atten;
            end
        end else if (step) begin
            if (mute_req) begin
                if (state_q != MUTED) begin
                    if (base == ATT_TOP || base_inc == ATT_TOP) begin
                        state_d = MUTED;
                        cur_d   = ATT_TOP;
                    end else begin
                        state_d = RAMP_DOWN;
                        cur_d   = base_inc;
                    end
                end
            end else if (state_q != UNMUTED) begin
                if (cur_q == '0 || cur_dec <= atten) begin
                    state_d = UNMUTED;
                    cur_d   = atten;
                end else begin
                    state_d = RAMP_UP;
                    cur_d   = cur_dec;
                end
            end else begin
                cur_d = atten;
            end
        end
    end

    // Mute state, current attenuation and ramp divider.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= MUTED;
            cur_q   <= ATT_TOP;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            div_q   <= div_d;
        end
    end

    // S1 sum and S2 shift/mute, each advancing behind the strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            sum_l_q  <= '0;
            sum_r_q  <= '0;
            shl_l_q  <= '0;
            shl_r_q  <= '0;
        end else begin
            s1_vld_q <= sample_clk_en;
            s2_vld_q <= s1_vld_q;
            if (sample_clk_en) begin
                sum_l_q <= SW1'(channel_a) + SW1'(channel_c);
                sum_r_q <= SW1'(channel_b) + SW1'(channel_d);
            end
            if (s1_vld_q) begin
                if (state_q == MUTED) begin
                    shl_l_q <= '0;
                    shl_r_q <= '0;
                end else begin
                    shl_l_q <= sum_l_q >>> cur_q;
                    shl_r_q <= sum_r_q >>> cur_q;
                end
            end
        end
    end

    sample_saturate #(.W(SAMPLE_WIDTH)) u_sat_l (
        .in_i   (shl_l_q),
        .out_o  (sat_l),
        .clip_o (clip_l_raw)
    );

    sample_saturate #(.W(SAMPLE_WIDTH)) u_sat_r (
        .in_i   (shl_r_q),
        .out_o  (sat_r),
        .clip_o (clip_r_raw)
    );

    assign load = s2_vld_q && (!valid_q || sample_ready);

    // Output handshake: load when free, otherwise drop and count.
    always_comb begin
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (valid_q && sample_ready) begin
            valid_d = 1'b0;
        end
        if (load) begin
            valid_d = 1'b1;
        end
        if (s2_vld_q && valid_q && !sample_ready && ovr_q != 8'hFF) begin
            ovr_d = ovr_q + 8'd1;
        end
    end

    // Held output pair, valid flag and overrun counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_l_q <= '0;
            out_r_q <= '0;
            valid_q <= 1'b0;
            ovr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            if (load) begin
                out_l_q <= sat_l;
                out_r_q <= sat_r;
            end
        end
    end

    assign sample_l     = out_l_q;
    assign sample_r     = out_r_q;
    assign sample_valid = valid_q;
    assign overrun_cnt  = ovr_q;
    assign ac_mute_n    = (state_q != MUTED);

`ifdef SAMPLE_MIXER_CLIP_DETECT_EN
    logic clip_l_q, clip_l_d, clip_r_q, clip_r_d;

    // Sticky clip flags; a new clip wins over a clear.
    always_comb begin
        clip_l_d = clip_l_q;
        clip_r_d = clip_r_q;
        if (clip_clr) begin
            clip_l_d = 1'b0;
            clip_r_d = 1'b0;
        end
        if (s2_vld_q && clip_l_raw) begin
            clip_l_d = 1'b1;
        end
        if (s2_vld_q && clip_r_raw) begin
            clip_r_d = 1'b1;
        end
    end

    // Clip flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clip_l_q <= 1'b0;
            clip_r_q <= 1'b0;
        end else begin
            clip_l_q <= clip_l_d;
            clip_r_q <= clip_r_d;
        end
    end

    assign clip_l = clip_l_q;
    assign clip_r = clip_r_q;
`else
    logic unused_clip;

    assign unused_clip = ^{clip_clr, clip_l_raw, clip_r_raw};
    assign clip_l      = 1'b0;
    assign clip_r      = 1'b0;
`endif

endmodule

// File: tb/tb_sample_mixer.sv
// Randomized bench for sample_mixer against a behavioural mixer model.
// Expected clip flags follow SAMPLE_MIXER_CLIP_DETECT_EN.
module tb_sample_mixer;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic sample_clk_en = 1'b0;
    logic signed [15:0] ch_a = '0, ch_b = '0, ch_c = '0, ch_d = '0;
    logic [3:0] atten = '0;
    logic mute_req = 1'b0;
    logic sample_ready = 1'b0;
    logic clip_clr = 1'b0;
    logic signed [15:0] sample_l, sample_r;
    logic sample_valid, ac_mute_n, clip_l, clip_r;
    logic [7:0] overrun_cnt;

`ifdef SAMPLE_MIXER_CLIP_DETECT_EN
    localparam bit CLIP_ON = 1'b1;
`else
    localparam bit CLIP_ON = 1'b0;
`endif

    sample_mixer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .sample_clk_en (sample_clk_en),
        .channel_a     (ch_a),
        .channel_b     (ch_b),
        .channel_c     (ch_c),
        .channel_d     (ch_d),
        .atten         (atten),
        .mute_req      (mute_req),
        .sample_l      (sample_l),
        .sample_r      (sample_r),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .ac_mute_n     (ac_mute_n),
        .overrun_cnt   (overrun_cnt),
        .clip_l        (clip_l),
        .clip_r        (clip_r),
        .clip_clr      (clip_clr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Model: attenuation level, fully-muted flag, tracking-atten flag.
    int m_lvl;
    bit m_muted, m_track;
    bit m_valid;
    int m_l, m_r, m_ovr;
    bit m_cl, m_cr;

    task automatic check(input string tag,
                         input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic model_reset();
        m_lvl = 15; m_muted = 1; m_track = 0;
        m_valid = 0; m_l = 0; m_r = 0; m_ovr = 0;
        m_cl = 0; m_cr = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"}, 32'(sample_valid), 32'(m_valid));
        check({tag, ".l"}, 32'(sample_l), m_l);
        check({tag, ".r"}, 32'(sample_r), m_r);
        check({tag, ".ovr"}, 32'(overrun_cnt), m_ovr);
        check({tag, ".mute_n"}, 32'(ac_mute_n), 32'(!m_muted));
        check({tag, ".clip_l"}, 32'(clip_l), 32'(m_cl));
        check({tag, ".clip_r"}, 32'(clip_r), 32'(m_cr));
    endtask

    task automatic win(input string tag, input int a, input int b,
                       input int c, input int d, input int att,
                       input bit mr, input bit rdy);
        int base, raw_l, raw_r, el, er;
        @(negedge clk);
        ch_a = 16'(a); ch_b = 16'(b); ch_c = 16'(c); ch_d = 16'(d);
        atten = 4'(att); mute_req = mr; sample_ready = rdy;
        sample_clk_en = 1'b1;
        if (mr) begin
            if (!m_muted) begin
                base = m_track ? att : m_lvl;
                m_lvl = (base + 1 > 15) ? 15 : base + 1;
                m_track = 0;
                m_muted = (m_lvl == 15);
            end
        end else if (!m_track) begin
            m_muted = 0;
            m_lvl = m_lvl - 1;
            if (m_lvl <= att) begin
                m_track = 1;
                m_lvl = att;
            end
        end else begin
            m_lvl = att;
        end
        if (m_valid && rdy) m_valid = 0;
        raw_l = m_muted ? 0 : ((a + c) >>> m_lvl);
        raw_r = m_muted ? 0 : ((b + d) >>> m_lvl);
        el = sat16(raw_l);
        er = sat16(raw_r);
        @(negedge clk);
        sample_clk_en = 1'b0;
        @(negedge clk);
        check({tag, ".vmid"}, 32'(sample_valid), 32'(m_valid));
        @(negedge clk);
        if (!m_valid) begin
            m_valid = 1; m_l = el; m_r = er;
        end else if (m_ovr < 255) begin
            m_ovr++;
        end
        if (CLIP_ON && el != raw_l) m_cl = 1;
        if (CLIP_ON && er != raw_r) m_cr = 1;
        check_all(tag);
        sample_ready = 1'b0;
    endtask

    task automatic idle(input string tag, input bit rdy, input bit clr);
        @(negedge clk);
        sample_ready = rdy;
        clip_clr = clr;
        @(negedge clk);
        if (m_valid && rdy) m_valid = 0;
        if (clr) begin m_cl = 0; m_cr = 0; end
        sample_ready = 1'b0;
        clip_clr = 1'b0;
        check_all(tag);
    endtask

    function automatic int rnd(input int lim);
        return int'($urandom_range(2 * lim)) - lim;
    endfunction

    initial begin
        bit mr;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 15; i++)
            win("unmute", rnd(12000), rnd(12000), rnd(12000), rnd(12000), 0, 0, 1);
        win("mix", 1000, 0, 2000, 0, 0, 0, 1);
        win("sat", 30000, -20000, 30000, -20000, 0, 0, 1);
        idle("clr", 0, 1);
        win("shift", -1001, 0, 0, 0, 2, 0, 1);
        idle("xfer", 1, 0);

        for (int i = 0; i < 3; i++)
            win("ovr", rnd(9000), rnd(9000), rnd(9000), rnd(9000), 0, 0, 0);
        idle("ovr_xfer", 1, 0);
        win("fresh", 1234, -4321, 100, 200, 0, 0, 0);
        idle("xfer2", 1, 0);

        for (int i = 0; i < 15; i++)
            win("mute", rnd(16000), rnd(16000), rnd(16000), rnd(16000), 0, 1, 1);
        for (int i = 0; i < 15; i++)
            win("unmute2", rnd(16000), rnd(16000), rnd(16000), rnd(16000), 0, 0, 1);
        for (int i = 0; i < 7; i++)
            win("down7", rnd(16000), rnd(16000), rnd(16000), rnd(16000), 0, 1, 1);
        for (int i = 0; i < 8; i++)
            win("back7", rnd(16000), rnd(16000), rnd(16000), rnd(16000), 0, 0, 1);

        mr = 0;
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(9) == 0) mr = !mr;
            win("rand", rnd(32768), rnd(32768), rnd(32768), rnd(32768),
                int'($urandom_range(15)), mr, 1'($urandom_range(1)));
            if ($urandom_range(3) == 0)
                idle("rand_idle", 1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        idle("pre_sat", 1, 0);
        for (int i = 0; i < 258; i++)
            win("ovr_sat", rnd(5000), rnd(5000), rnd(5000), rnd(5000), 3, 0, 0);

        idle("pre_arst", 1, 0);
        for (int i = 0; i < 16; i++)
            win("pre_up", 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++)
            win("rampdn", 30000, -30000, 30000, -30000, 0, 1, 0);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 model_reset();
        check_all("arst");
        @(negedge clk);
        reset_n = 1'b1;
        win("post_rst", 500, 600, 700, 800, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
